// File: rtl/if_prefetch_unit_pkg.sv
// Shared rv32i definitions for the pipeline stages.
// No logic: constants, the fetch queue entry layout and an alignment helper.
// Not applicable (no handshake of its own).
package if_prefetch_unit_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0: presented to ID whenever nothing valid is queued
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One queued fetch: address and the word read from it
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Instructions are word aligned; low address bits of a target are dropped
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and ID handshake.
// Pure wiring, no latency.
// ID backpressure travels on id_ready_i; the memory side never stalls.
interface if_prefetch_unit_if;
  import if_prefetch_unit_pkg::*;

  logic [XLEN-1:0] i_mem_addr;
  logic [XLEN-1:0] i_mem_rdata;
  logic            branch_taken_i;
  logic [XLEN-1:0] branch_target_i;
  logic            id_ready_i;
  logic            inst_valid_o;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] pc_o;

  // Prefetch unit side
  modport master (
    output i_mem_addr,
    input  i_mem_rdata,
    input  branch_taken_i,
    input  branch_target_i,
    input  id_ready_i,
    output inst_valid_o,
    output inst_o,
    output pc_o
  );

  // Memory / EX / ID side
  modport slave (
    input  i_mem_addr,
    output i_mem_rdata,
    output branch_taken_i,
    output branch_target_i,
    output id_ready_i,
    input  inst_valid_o,
    input  inst_o,
    input  pc_o
  );

endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries, with a flush input.
// Head visible the cycle after the push edge; no write-to-read bypass.
// Push refused when full unless a pop happens the same cycle; flush wins over both.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  // DEPTH is a power of two, so pointers wrap naturally at AW bits
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch: fetches sequentially into a queue feeding ID, redirects on taken branch.
// Fetch at cycle N is presented at N+1 earliest; redirect target presented two cycles later.
// id_ready_i low holds the head; fetching stops only when the queue is full and not draining.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  if_prefetch_unit_if.master  bus
);

  logic [XLEN-1:0] fetch_pc;
  logic            redirect;
  logic            q_full;
  logic            q_empty;
  logic            pop;
  logic            push_en;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic [ENTRY_W-1:0] head_bits;

  assign redirect = bus.branch_taken_i;
  assign pop      = !q_empty && bus.id_ready_i;
  // A pop frees a slot in the same edge, so a full queue still accepts a fetch
  assign push_en  = (!q_full || pop) && !redirect;

  assign wr_entry.pc   = fetch_pc;
  assign wr_entry.inst = bus.i_mem_rdata;
  assign head          = fetch_entry_t'(head_bits);

  assign bus.i_mem_addr   = fetch_pc;
  assign bus.inst_valid_o = !q_empty;
  assign bus.inst_o       = q_empty ? NOP_INST : head.inst;
  assign bus.pc_o         = q_empty ? '0 : head.pc;

  // Fetch address: reset, then redirect, then sequential advance on each accepted fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= word_align(bus.branch_target_i);
    end else if (push_en) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Redirect flushes stale entries and suppresses the same-cycle push/pop
  if_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push_en),
    .pop   (pop && !redirect),
    .wdata (wr_entry),
    .rdata (head_bits),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule
